// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit owning the HI/LO pair.
// Multiply is shift-add and divide is restoring division. Both take one
// operand bit per cycle (WIDTH iteration edges), followed by one FIX edge
// that applies the sign correction and writes HI/LO.
// Divide by zero completes on the accept edge without iterating.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       mf_sel,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hl_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [CW-1:0]     count_r;
    logic [WIDTH-1:0]  acc_hi_r;      // product high half during MUL
    logic [WIDTH-1:0]  acc_lo_r;      // multiplier / product low half, or dividend / quotient
    logic [WIDTH-1:0]  oper_r;        // multiplicand magnitude or divisor magnitude
    logic [WIDTH:0]    rem_r;         // partial remainder during DIV
    logic              neg_prod_r;
    logic              neg_quot_r;
    logic              neg_rem_r;
    logic              op_div_r;
    logic [WIDTH-1:0]  hi_r;
    logic [WIDTH-1:0]  lo_r;
    logic              busy_r;
    logic              dbz_r;

    logic              accept_mult_s;
    logic              accept_div_s;
    logic              div_zero_s;
    logic [WIDTH-1:0]  mag_a_s;
    logic [WIDTH-1:0]  mag_b_s;
    logic [WIDTH:0]    sum_s;
    logic [WIDTH:0]    shifted_s;
    logic [WIDTH:0]    diff_s;
    logic              ge_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]  quot_fix_s;
    logic [WIDTH-1:0]  rem_fix_s;

    // Two's-complement magnitude; only signed operands with the top bit set are negated.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return (~v) + WIDTH'(1);
        end else begin
            return v;
        end
    endfunction

    // Accept decode, operand magnitudes and one iteration step of each algorithm.
    always_comb begin
        accept_mult_s = (state_r == IDLE) && start_mult;
        accept_div_s  = (state_r == IDLE) && start_div && !start_mult;
        div_zero_s    = accept_div_s && (op_b == {WIDTH{1'b0}});
        mag_a_s       = magnitude(op_a, signed_op);
        mag_b_s       = magnitude(op_b, signed_op);
        if (acc_lo_r[0]) begin
            sum_s = {1'b0, acc_hi_r} + {1'b0, oper_r};
        end else begin
            sum_s = {1'b0, acc_hi_r};
        end
        shifted_s = {rem_r[WIDTH-1:0], acc_lo_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, oper_r};
        ge_s      = (shifted_s >= {1'b0, oper_r});
    end

    // Sign correction applied on the FIX edge.
    always_comb begin
        if (neg_prod_r) begin
            prod_fix_s = (~{acc_hi_r, acc_lo_r}) + (2*WIDTH)'(1);
        end else begin
            prod_fix_s = {acc_hi_r, acc_lo_r};
        end
        if (neg_quot_r) begin
            quot_fix_s = (~acc_lo_r) + WIDTH'(1);
        end else begin
            quot_fix_s = acc_lo_r;
        end
        if (neg_rem_r) begin
            rem_fix_s = (~rem_r[WIDTH-1:0]) + WIDTH'(1);
        end else begin
            rem_fix_s = rem_r[WIDTH-1:0];
        end
    end

    // Next-state logic for the sequencer FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_mult_s) begin
                    state_next_s = MUL;
                end else if (accept_div_s && !div_zero_s) begin
                    state_next_s = DIV;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL: begin
                if (count_r == LAST_ITER) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = MUL;
                end
            end
            DIV: begin
                if (count_r == LAST_ITER) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = DIV;
                end
            end
            FIX:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register; busy is registered alongside so it tracks the state with no decode delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Datapath: operand latch on accept, per-cycle iteration, HI/LO write at FIX or divide-by-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r    <= {CW{1'b0}};
            acc_hi_r   <= {WIDTH{1'b0}};
            acc_lo_r   <= {WIDTH{1'b0}};
            oper_r     <= {WIDTH{1'b0}};
            rem_r      <= {(WIDTH+1){1'b0}};
            neg_prod_r <= 1'b0;
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
            op_div_r   <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            dbz_r      <= 1'b0;
        end else begin
            dbz_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_mult_s || (accept_div_s && !div_zero_s)) begin
                        count_r    <= {CW{1'b0}};
                        acc_hi_r   <= {WIDTH{1'b0}};
                        rem_r      <= {(WIDTH+1){1'b0}};
                        neg_prod_r <= signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_quot_r <= signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_rem_r  <= signed_op && op_a[WIDTH-1];
                        op_div_r   <= accept_div_s;
                        // Multiply keeps the multiplier in acc_lo; divide shifts the dividend out of it.
                        acc_lo_r   <= accept_mult_s ? mag_b_s : mag_a_s;
                        oper_r     <= accept_mult_s ? mag_a_s : mag_b_s;
                    end else if (div_zero_s) begin
                        hi_r  <= op_a;
                        lo_r  <= {WIDTH{1'b1}};
                        dbz_r <= 1'b1;
                    end
                end
                MUL: begin
                    count_r  <= count_r + CW'(1);
                    acc_hi_r <= sum_s[WIDTH:1];
                    acc_lo_r <= {sum_s[0], acc_lo_r[WIDTH-1:1]};
                end
                DIV: begin
                    count_r  <= count_r + CW'(1);
                    rem_r    <= ge_s ? diff_s : shifted_s;
                    acc_lo_r <= {acc_lo_r[WIDTH-2:0], ge_s};
                end
                FIX: begin
                    count_r <= {CW{1'b0}};
                    if (op_div_r) begin
                        lo_r <= quot_fix_s;
                        hi_r <= rem_fix_s;
                    end else begin
                        {hi_r, lo_r} <= prod_fix_s;
                    end
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign stall       = busy_r & (start_mult | start_div | mf_sel[1]);
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign hl_out      = mf_sel[0] ? lo_r : hi_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [1:0]  mf_sel = 2'b00;
    logic        stall;
    logic        busy;
    logic [31:0] hl_out;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_mult(start_mult), .start_div(start_div),
        .signed_op(signed_op), .op_a(op_a), .op_b(op_b), .mf_sel(mf_sel),
        .stall(stall), .busy(busy), .hl_out(hl_out), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle start; returns just after the accept edge (edge 0).
    task automatic start_op(input logic m, input logic d, input logic s,
                            input logic [31:0] a, input logic [31:0] b);
        start_mult = m; start_div = d; signed_op = s; op_a = a; op_b = b;
        step();
        start_mult = 1'b0; start_div = 1'b0;
    endtask

    // Counts busy cycles from just after the accept edge, bounded.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            step();
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mult_signed();
        int cyc;
        start_op(1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFFFFFD);
        wait_idle(cyc);
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL mult_busy_cycles: got %0d want 33", cyc); end
        n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin n_err++; $display("FAIL mult_signed: got %h want ffffffffffffffeb", {hi, lo}); end
    endtask

    task automatic test_multu();
        int cyc;
        start_op(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(cyc);
        n_cmp++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin n_err++; $display("FAIL multu: got %h want fffffffe00000001", {hi, lo}); end
    endtask

    task automatic test_div();
        int cyc;
        start_op(1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc);
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL div_busy_cycles: got %0d want 33", cyc); end
        n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_err++; $display("FAIL div_signed: got %h want fffffffffffffffd", {hi, lo}); end
        start_op(1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cyc);
        n_cmp++; if ({hi, lo} !== 64'h00000000_80000000) begin n_err++; $display("FAIL div_overflow: got %h want 0000000080000000", {hi, lo}); end
    endtask

    task automatic test_mf_stall();
        int cyc;
        start_op(1'b1, 1'b0, 1'b1, 32'd3, 32'd4);
        repeat (5) step();
        mf_sel = 2'b11;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL mf_stall_high: got %b want 1", stall); end
        n_cmp++; if (hl_out !== 32'h80000000) begin n_err++; $display("FAIL mf_old_lo: got %h want 80000000", hl_out); end
        cyc = 0;
        while (stall && cyc < 100) begin
            step();
            cyc++;
        end
        n_cmp++; if (cyc !== 28) begin n_err++; $display("FAIL mf_release_cycle: got %0d want 28", cyc); end
        n_cmp++; if (hl_out !== 32'h0000000C) begin n_err++; $display("FAIL mf_new_lo: got %h want 0000000c", hl_out); end
        mf_sel = 2'b10;
        #1;
        n_cmp++; if (hl_out !== 32'h00000000) begin n_err++; $display("FAIL mf_hi: got %h want 00000000", hl_out); end
        mf_sel = 2'b00;
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_mult = 1'b1; signed_op = 1'b0; op_a = 32'd5; op_b = 32'd6;
        step();
        op_a = 32'd7; op_b = 32'd8;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall: got %b want 1", stall); end
        repeat (33) step();
        n_cmp++; if ({busy, stall} !== 2'b00) begin n_err++; $display("FAIL b2b_release: got busy/stall %b want 00", {busy, stall}); end
        n_cmp++; if (lo !== 32'd30) begin n_err++; $display("FAIL b2b_first: got %0d want 30", lo); end
        step();
        start_mult = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept34: got %b want 1", busy); end
        wait_idle(cyc);
        n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL b2b_cycles: got %0d want 33", cyc); end
        n_cmp++; if ({hi, lo} !== 64'd56) begin n_err++; $display("FAIL b2b_second: got %h want 56", {hi, lo}); end
    endtask

    task automatic test_div_zero();
        start_div = 1'b1; signed_op = 1'b0; op_a = 32'd5; op_b = 32'd0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL dz_stall_pre: got %b want 0", stall); end
        step();
        n_cmp++; if ({hi, lo} !== 64'h00000005_FFFFFFFF) begin n_err++; $display("FAIL dz_hilo: got %h want 00000005ffffffff", {hi, lo}); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_pulse: got %b want 1", div_by_zero); end
        n_cmp++; if ({busy, stall} !== 2'b00) begin n_err++; $display("FAIL dz_busy: got busy/stall %b want 00", {busy, stall}); end
        start_div = 1'b0;
        step();
        n_cmp++; if ({div_by_zero, busy} !== 2'b00) begin n_err++; $display("FAIL dz_pulse_end: got dbz/busy %b want 00", {div_by_zero, busy}); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_op(1'b1, 1'b0, 1'b1, 32'd100, 32'd100);
        repeat (10) step();
        mf_sel = 2'b10;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rm_stall_before: got %b want 1", stall); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, stall} !== 2'b00) begin n_err++; $display("FAIL rm_busy: got busy/stall %b want 00", {busy, stall}); end
        n_cmp++; if ({hi, lo, hl_out} !== 96'd0) begin n_err++; $display("FAIL rm_hilo: got %h want 0", {hi, lo, hl_out}); end
        mf_sel = 2'b00;
        step();
        rst_n = 1'b1;
        step();
        start_op(1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
        wait_idle(cyc);
        n_cmp++; if ({hi, lo} !== 64'd12) begin n_err++; $display("FAIL rm_after: got %h want 12", {hi, lo}); end
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_multu();
        test_div();
        test_mf_stall();
        test_back_to_back();
        test_div_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller that owns the HI/LO register pair for the pipelined MIPS core. It replaces single-cycle HI/LO arithmetic in the execute stage. A MULT/MULTU/DIV/DIVU is accepted from E and run over 34 cycles. A stall request to the hazard unit freezes F/D/E whenever a later multiply, divide or MFHI/MFLO reaches E before the result is ready.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_mult  in  1  multiply request in E (the multE qualifier).
- start_div  in  1  divide request in E (the divE qualifier).
- signed_op  in  1  1 = MULT/DIV, 0 = MULTU/DIVU; sampled with the start.
- op_a  in  WIDTH  SrcAE: multiplicand or dividend.
- op_b  in  WIDTH  SrcBE: multiplier or divisor.
- mf_sel  in  2  2'b10 = MFHI, 2'b11 = MFLO, 2'b0x = none.
- stall  out  1  to the hazard unit; holds F, D and E and flushes M.
- busy  out  1  an operation is in flight.
- hl_out  out  WIDTH  HI or LO per mf_sel[0]; combinational from the registers.
- hi, lo  out  WIDTH  architectural HI/LO registers.
- div_by_zero  out  1  one-cycle pulse on a divide by zero.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Accept rule:
  - A start is accepted only in IDLE.
  - start_mult has priority over start_div.
  - On the accept edge the block latches |op_a| and |op_b| (magnitudes only when signed_op=1), the neg_prod/neg_quot/neg_rem flags and the operation type, and clears count.
- MUL: shift-add, one multiplier bit per cycle. The 64-bit accumulator is {acc_hi, acc_lo}.
- DIV: restoring division, one quotient bit per cycle. The remainder register is WIDTH+1 bits.
- Transition to FIX: when count reaches WIDTH-1 the state moves to FIX on the next edge, so there are WIDTH iteration edges.
- FIX: applies the sign correction and writes HI/LO.
  - Multiply: {HI,LO} = neg ? -product : product (64-bit two's complement).
  - Divide: LO = quotient, negated if the operand signs differ; HI = remainder, taking the sign of the dividend.
  - After FIX the state returns to IDLE.
- Special cases:
  - Divide by zero (op_b == 0 at accept): no iteration. HI=op_a, LO=all-ones, written on the accept edge; div_by_zero is high for the following cycle; busy never asserts.
  - Signed 0x80000000 / -1: LO=0x80000000, HI=0 (wrap, no trap).
- Stall and forwarding:
  - stall = busy & (start_mult | start_div | mf_sel[1]), combinational.
  - A request arriving while busy is ignored but kept stalled. The E stage keeps presenting it and it is accepted on the first edge with state IDLE.
  - mf_sel in IDLE never stalls and reads the current HI/LO. If a start and an MF arrive together in IDLE, the MF sees the old HI/LO.
- Reset (asynchronous, at any time including mid-operation): state=IDLE, count=0, HI=LO=0, busy=0, stall=0, div_by_zero=0, all internal accumulators 0. Any operation in flight is discarded.

## Timing
- Edge 0 accepts the start. Iteration edges are 1..32. Edge 33 (FIX) writes HI/LO and sets state to IDLE.
- busy is high in the cycles after edges 0 through 32 and low after edge 33.
- A stalled MFHI/MFLO is released in the cycle after edge 33 and sees the new value on hl_out in that same cycle.
- Back-to-back: a second held start is accepted at edge 34, giving a throughput of one operation per 34 cycles.
- HI/LO change only at FIX, or at the accept edge for a divide by zero.
- hi, lo and hl_out reflect the registers with no added latency.

## Test plan
- Signed MULT 7 × 0xFFFFFFFD (-3) -> after edge 33: HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Signed DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT 3 × 4, then mf_sel=2'b11 five cycles later -> stall high until busy drops; on release hl_out=0x0000000C. A second MULT held behind it is accepted at edge 34.
- DIVU 5 / 0 -> HI=5, LO=0xFFFFFFFF after one edge; div_by_zero pulses for 1 cycle; busy and stall stay 0.
- rst_n pulled low at iteration 10 of a MULT -> busy, stall, HI and LO go to 0 immediately. A following MULTU 3 × 4 yields LO=12, HI=0.
